bus_bridge_req_queue: RTL and testbench
=======================================

Name: bus_bridge_req_queue

Overview:
Request buffer and sequencer directly upstream of the bus bridge initiator interface. It accepts bridge requests (bus_bridge_req_t) from the bridge target side into a DEPTH-entry FIFO and issues them to the initiator interface one at a time. It captures each response (bus_bridge_resp_t) and returns it upstream in request order. A response-wait watchdog raises a sticky error flag.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
TIMEOUT_CYCLES, 1024, cycles in S_WAIT before timeout_err sets; minimum 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
up_req_valid  input  1  upstream request valid
up_req_ready  output  1  upstream request accepted when valid&ready
up_req_payload  input  bus_bridge_req_t  addr[15:0], write_data[7:0], is_write
up_resp_valid  output  1  response to upstream valid
up_resp_ready  input  1  upstream accepts response
up_resp_payload  output  bus_bridge_resp_t  is_write, read_data[7:0]
dn_req_valid  output  1  to initiator req_valid
dn_req_ready  input  1  from initiator req_ready
dn_req_payload  output  bus_bridge_req_t  to initiator req_payload
dn_resp_valid  input  1  from initiator resp_valid
dn_resp_ready  output  1  to initiator resp_ready
dn_resp_payload  input  bus_bridge_resp_t  from initiator resp_payload
occupancy  output  $clog2(DEPTH)+1  FIFO entries held
busy  output  1  (state != S_IDLE) or (occupancy != 0)
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n low): FIFO emptied with rd_ptr=wr_ptr=0, occupancy=0, state=S_IDLE, response register cleared, wait counter=0, timeout_err=0. All valid/ready outputs and busy read 0 while in reset. Reset mid-transaction discards queued and in-flight requests without producing a response.
- FIFO: up_req_ready = (occupancy != DEPTH), combinational from registered count. Push on up_req_valid&up_req_ready writes mem[wr_ptr]. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave occupancy unchanged. There is no same-cycle bypass: a request is visible downstream the cycle after its push edge. When full, the push waits for a later cycle; a pop that same cycle does not make up_req_ready rise within that cycle.
- dn_req_payload = mem[rd_ptr] at all times. dn_resp_ready = (state == S_WAIT). up_resp_valid = (state == S_RESP). up_resp_payload = response register.
- FSM:
  - S_IDLE: dn_req_valid = (occupancy != 0). On dn_req_valid&dn_req_ready: pop, clear wait counter, go to S_WAIT.
  - S_WAIT: dn_req_valid=0. On dn_resp_valid: capture dn_resp_payload into the response register and go to S_RESP. Otherwise the wait counter increments, saturating. When it reaches TIMEOUT_CYCLES-1, timeout_err sets. The FSM keeps waiting; the watchdog never aborts the transaction.
  - S_RESP: hold the response. On up_resp_ready, go to S_IDLE. The next queued request can present on dn_req_valid the following cycle.
- Only one request is outstanding downstream. Ordering is strictly FIFO.
- Latency, empty queue, downstream ready:
  - push at edge k -> dn_req_valid high after edge k
  - downstream handshake at edge k+1 -> S_WAIT
  - dn_resp_valid captured at edge m -> up_resp_valid high after edge m
- Upstream may keep pushing while a transaction is in flight, up to DEPTH entries.
- timeout_err clears only by reset.
- Unknown or illegal state encodings return to S_IDLE.

Test Plan:
- Single write {addr=16'h1234, data=8'hA5, is_write=1}, dn_req_ready=1, dn_resp returned 3 cycles after issue -> dn_req_payload matches; up_resp_payload {is_write=1, read_data=8'h00}; occupancy 1->0; busy drops after up_resp_ready.
- Fill queue: push 5 reads (addr 16'h0010..16'h0014) with dn_req_ready=0, DEPTH=4 -> up_req_ready low after 4th push, occupancy=4. Release -> issued in order 0010..0013. 5th push accepted once a slot frees; ordering preserved, wrap-around exercised.
- Read responses read_data 8'h11,8'h22,8'h33 with up_resp_ready held low 5 cycles each -> responses delivered in order. dn_resp_ready low during S_RESP; no overwrite or loss.
- Simultaneous push and pop at occupancy=2 -> occupancy stays 2; no entry lost or duplicated.
- TIMEOUT_CYCLES=8, no dn_resp_valid -> timeout_err rises on the 8th S_WAIT cycle and stays high. A late response 20 cycles later still reaches upstream.
- Assert rst_n low while in S_WAIT with 3 entries queued -> immediately occupancy=0, dn_req_valid=0, up_resp_valid=0, timeout_err=0. After release, no stale response is emitted.

Source files
------------

// File: rtl/bus_bridge_req_queue.sv
// -----------------------------------------------------------------------------
// bus_bridge_req_queue
//
// Request buffer and sequencer that sits directly upstream of the bus bridge
// initiator. Requests from the bridge target side are queued in a DEPTH-entry
// FIFO. They are issued downstream one at a time. Each response is captured and
// returned upstream in request order. A watchdog raises a sticky flag when a
// response takes too long to arrive. The watchdog never aborts the transaction.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   up_req_*          upstream request channel (valid/ready/payload)
//   up_resp_*         upstream response channel (valid/ready/payload)
//   dn_req_*          request channel to the initiator interface
//   dn_resp_*         response channel from the initiator interface
//   occupancy         number of FIFO entries currently held
//   busy              a transaction is in flight or requests are queued
//   timeout_err       sticky response-wait watchdog flag, cleared by reset only
// -----------------------------------------------------------------------------

package bus_bridge_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  write_data;
        logic        is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic        is_write;
        logic [7:0]  read_data;
    } bus_bridge_resp_t;

endpackage

module bus_bridge_req_queue
    import bus_bridge_pkg::*;
#(
    parameter int DEPTH          = 4,    // power of two, >= 2
    parameter int TIMEOUT_CYCLES = 1024  // >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     up_req_valid,
    output logic                     up_req_ready,
    input  bus_bridge_req_t          up_req_payload,

    output logic                     up_resp_valid,
    input  logic                     up_resp_ready,
    output bus_bridge_resp_t         up_resp_payload,

    output logic                     dn_req_valid,
    input  logic                     dn_req_ready,
    output bus_bridge_req_t          dn_req_payload,

    input  logic                     dn_resp_valid,
    output logic                     dn_resp_ready,
    input  bus_bridge_resp_t         dn_resp_payload,

    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_PRE  = WAIT_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    bus_bridge_req_t  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    bus_bridge_resp_t  resp_reg;

    logic push;
    logic pop;

    // NOTE: rst_n gates the ready combinationally. The empty count alone would
    // otherwise advertise space while the block is held in reset.
    assign up_req_ready    = rst_n && (count != FULL_CNT);
    assign dn_req_valid    = (state == S_IDLE) && (count != '0);
    assign dn_req_payload  = mem[rd_ptr];
    assign dn_resp_ready   = (state == S_WAIT);
    assign up_resp_valid   = (state == S_RESP);
    assign up_resp_payload = resp_reg;
    assign occupancy       = count;
    assign busy            = (state != S_IDLE) || (count != '0);

    assign push = up_req_valid && up_req_ready;
    assign pop  = dn_req_valid && dn_req_ready;

    // NOTE: the storage array has no reset. Only the pointers and the count
    // define which entries are live, so stale contents are never observed as
    // valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= up_req_payload;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
    // NOTE: all sequential state uses non-blocking assignments. This lets every
    // block read the pre-edge values of the other blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer: only one request is outstanding downstream. The watchdog
    // counter saturates at TIMEOUT_CYCLES-1. It sets the sticky flag on the same
    // edge that it reaches that value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            resp_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (dn_resp_valid) begin
                        resp_reg <= dn_resp_payload;
                        state    <= S_RESP;
                    end else if (wait_cnt != WAIT_LAST) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_PRE) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (up_resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge_req_queue.sv
module tb_bus_bridge_req_queue;
    import bus_bridge_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             up_req_valid;
    logic             up_req_ready;
    bus_bridge_req_t  up_req_payload;
    logic             up_resp_valid;
    logic             up_resp_ready;
    bus_bridge_resp_t up_resp_payload;
    logic             dn_req_valid;
    logic             dn_req_ready;
    bus_bridge_req_t  dn_req_payload;
    logic             dn_resp_valid;
    logic             dn_resp_ready;
    bus_bridge_resp_t dn_resp_payload;
    logic [2:0]       occupancy;
    logic             busy;
    logic             timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    bus_bridge_req_t  req_q[$];
    bus_bridge_resp_t resp_q[$];

    bus_bridge_req_queue #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .up_req_valid   (up_req_valid),
        .up_req_ready   (up_req_ready),
        .up_req_payload (up_req_payload),
        .up_resp_valid  (up_resp_valid),
        .up_resp_ready  (up_resp_ready),
        .up_resp_payload(up_resp_payload),
        .dn_req_valid   (dn_req_valid),
        .dn_req_ready   (dn_req_ready),
        .dn_req_payload (dn_req_payload),
        .dn_resp_valid  (dn_resp_valid),
        .dn_resp_ready  (dn_resp_ready),
        .dn_resp_payload(dn_resp_payload),
        .occupancy      (occupancy),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples handshakes at the falling edge, updates the scoreboard, and then
    // advances to just after the next rising edge.
    task automatic step();
        bus_bridge_req_t  exp_req;
        bus_bridge_resp_t exp_resp;
        @(negedge clk);
        if (dn_req_valid && dn_req_ready) begin
            if (req_q.size() == 0) begin
                check("dn_req_spurious", 32'(req_q.size()), 32'd1);
            end else begin
                exp_req = req_q.pop_front();
                check("dn_req_order", 32'(dn_req_payload), 32'(exp_req));
            end
        end
        if (up_req_valid && up_req_ready) req_q.push_back(up_req_payload);
        if (up_resp_valid && up_resp_ready) begin
            if (resp_q.size() == 0) begin
                check("up_resp_spurious", 32'(resp_q.size()), 32'd1);
            end else begin
                exp_resp = resp_q.pop_front();
                check("up_resp_order", 32'(up_resp_payload), 32'(exp_resp));
            end
        end
        if (dn_resp_valid && dn_resp_ready) resp_q.push_back(dn_resp_payload);
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [15:0] addr, input logic [7:0] data, input logic wr);
        up_req_valid   = 1'b1;
        up_req_payload = '{addr: addr, write_data: data, is_write: wr};
        step();
        up_req_valid   = 1'b0;
    endtask

    // Waits for the next issued request and returns a response. The response is
    // then held upstream for 'hold' cycles before it is accepted.
    task automatic serve(input logic [7:0] data, input logic wr, input int hold);
        int n = 0;
        while (!dn_resp_ready && n < 50) begin
            step();
            n++;
        end
        check("serve_wait_issue", 32'(dn_resp_ready), 32'd1);
        dn_resp_valid   = 1'b1;
        dn_resp_payload = '{is_write: wr, read_data: data};
        step();
        // A garbage response is presented while the captured one is held.
        // It must not be taken.
        dn_resp_payload = '{is_write: 1'b1, read_data: 8'hEE};
        dn_resp_valid   = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            check("resp_hold_valid", 32'(up_resp_valid), 32'd1);
            check("resp_hold_dn_ready", 32'(dn_resp_ready), 32'd0);
            step();
        end
        dn_resp_valid = 1'b0;
        up_resp_ready = 1'b1;
        step();
        up_resp_ready = 1'b0;
        check("resp_accepted", 32'(up_resp_valid), 32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        up_req_valid    = 1'b0;
        up_req_payload  = '0;
        up_resp_ready   = 1'b0;
        dn_req_ready    = 1'b0;
        dn_resp_valid   = 1'b0;
        dn_resp_payload = '0;

        // Reset state
        #12;
        check("rst_up_req_ready", 32'(up_req_ready), 32'd0);
        check("rst_dn_req_valid", 32'(dn_req_valid), 32'd0);
        check("rst_up_resp_valid", 32'(up_resp_valid), 32'd0);
        check("rst_dn_resp_ready", 32'(dn_resp_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("idle_up_req_ready", 32'(up_req_ready), 32'd1);

        // Single write, response returned three cycles after issue
        dn_req_ready = 1'b1;
        push_req(16'h1234, 8'hA5, 1'b1);
        check("t1_occ_after_push", 32'(occupancy), 32'd1);
        check("t1_dn_req_valid", 32'(dn_req_valid), 32'd1);
        check("t1_dn_req_payload", 32'(dn_req_payload), 32'({16'h1234, 8'hA5, 1'b1}));
        check("t1_busy", 32'(busy), 32'd1);
        step();
        check("t1_occ_after_issue", 32'(occupancy), 32'd0);
        check("t1_dn_resp_ready", 32'(dn_resp_ready), 32'd1);
        check("t1_dn_req_valid_wait", 32'(dn_req_valid), 32'd0);
        step();
        step();
        dn_resp_valid   = 1'b1;
        dn_resp_payload = '{is_write: 1'b1, read_data: 8'h00};
        step();
        dn_resp_valid = 1'b0;
        check("t1_up_resp_valid", 32'(up_resp_valid), 32'd1);
        check("t1_up_resp_payload", 32'(up_resp_payload), 32'({1'b1, 8'h00}));
        check("t1_dn_resp_ready_resp", 32'(dn_resp_ready), 32'd0);
        up_resp_ready = 1'b1;
        step();
        up_resp_ready = 1'b0;
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_up_resp_valid_done", 32'(up_resp_valid), 32'd0);

        // Fill the queue while downstream stalls
        dn_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_req(16'h0010 + 16'(i), 8'h00, 1'b0);
        end
        check("t2_occ_full", 32'(occupancy), 32'd4);
        check("t2_up_req_ready_full", 32'(up_req_ready), 32'd0);
        up_req_valid   = 1'b1;
        up_req_payload = '{addr: 16'h0014, write_data: 8'h00, is_write: 1'b0};
        step();
        step();
        check("t2_occ_still_full", 32'(occupancy), 32'd4);
        dn_req_ready = 1'b1;
        #1;
        check("t2_ready_low_during_pop", 32'(up_req_ready), 32'd0);
        step();
        check("t2_occ_after_pop", 32'(occupancy), 32'd3);
        check("t2_ready_after_pop", 32'(up_req_ready), 32'd1);
        step();
        up_req_valid = 1'b0;
        check("t2_occ_refilled", 32'(occupancy), 32'd4);
        serve(8'h11, 1'b0, 5);
        serve(8'h22, 1'b0, 5);
        serve(8'h33, 1'b0, 5);
        serve(8'h44, 1'b0, 0);
        serve(8'h55, 1'b0, 0);
        check("t2_drained", 32'(occupancy), 32'd0);

        // Simultaneous push and pop at occupancy 2
        dn_req_ready = 1'b0;
        push_req(16'hA000, 8'h01, 1'b1);
        push_req(16'hA001, 8'h02, 1'b0);
        check("t4_occ_two", 32'(occupancy), 32'd2);
        dn_req_ready = 1'b1;
        push_req(16'hA002, 8'h03, 1'b1);
        check("t4_occ_unchanged", 32'(occupancy), 32'd2);
        serve(8'h00, 1'b1, 0);
        serve(8'h66, 1'b0, 1);
        serve(8'h00, 1'b1, 0);
        check("t4_drained", 32'(occupancy), 32'd0);

        // Watchdog with TIMEOUT_CYCLES = 8
        push_req(16'hBEEF, 8'h00, 1'b0);
        step();
        check("t5_in_wait", 32'(dn_resp_ready), 32'd1);
        check("t5_timeout_c1", 32'(timeout_err), 32'd0);
        repeat (6) step();
        check("t5_timeout_c7", 32'(timeout_err), 32'd0);
        step();
        check("t5_timeout_c8", 32'(timeout_err), 32'd1);
        repeat (20) step();
        check("t5_timeout_sticky", 32'(timeout_err), 32'd1);
        check("t5_still_waiting", 32'(dn_resp_ready), 32'd1);
        serve(8'h77, 1'b0, 0);
        check("t5_timeout_after_resp", 32'(timeout_err), 32'd1);

        // Reset in S_WAIT with three entries queued
        push_req(16'hC000, 8'h00, 1'b0);
        push_req(16'hC001, 8'h00, 1'b0);
        push_req(16'hC002, 8'h00, 1'b0);
        push_req(16'hC003, 8'h00, 1'b0);
        check("t6_occ_three", 32'(occupancy), 32'd3);
        check("t6_in_wait", 32'(dn_resp_ready), 32'd1);
        check("t6_timeout_before", 32'(timeout_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_occ", 32'(occupancy), 32'd0);
        check("t6_rst_dn_req_valid", 32'(dn_req_valid), 32'd0);
        check("t6_rst_up_resp_valid", 32'(up_resp_valid), 32'd0);
        check("t6_rst_timeout", 32'(timeout_err), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_up_req_ready", 32'(up_req_ready), 32'd0);
        req_q.delete();
        resp_q.delete();
        step();
        step();
        rst_n         = 1'b1;
        up_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t6_no_stale_resp", 32'(up_resp_valid), 32'd0);
            check("t6_no_stale_req", 32'(dn_req_valid), 32'd0);
            step();
        end
        up_resp_ready = 1'b0;
        push_req(16'hD00D, 8'h5A, 1'b1);
        serve(8'h00, 1'b1, 2);
        check("t6_final_idle", 32'(busy), 32'd0);

        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
